dense_fc_mac_seq: RTL and testbench

DENSE_FC_MAC_SEQ -- requirements
Module: dense_fc_mac_seq

---
 rtl/dense_fc_mac_seq.sv | 146 ++++++++++++++
 tb/tb_dense_fc_mac_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_fc_mac_seq.sv
// Sequential int8 fully-connected layer: one multiply-accumulate per cycle,
// one signed ACC_W result per output neuron via a valid/ready handshake.
// Optional build macro: DENSE_FC_RELU_EN clamps negative results to zero.
module dense_fc_mac_seq #(
  parameter int IN_LEN  = 64,
  parameter int OUT_LEN = 16,
  parameter int ACC_W   = 32
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  output logic                                             busy,
  output logic                                             done,
  output logic [$clog2(IN_LEN)-1:0]                        act_addr,
  output logic                                             act_read_enable,
  input  logic signed [7:0]                                act_data,
  output logic [$clog2(IN_LEN*OUT_LEN)-1:0]                wgt_addr,
  output logic                                             wgt_read_enable,
  input  logic signed [7:0]                                wgt_data,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic signed [ACC_W-1:0]                          out_data,
  output logic [((OUT_LEN > 1) ? $clog2(OUT_LEN) : 1)-1:0] out_index
);

  localparam int AW = $clog2(IN_LEN);
  localparam int WW = $clog2(IN_LEN*OUT_LEN);
  localparam int NW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [AW-1:0] I_LAST = AW'(IN_LEN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(OUT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUTPUT
  } state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            i_q, i_d;
  logic [NW-1:0]            n_q, n_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     pend_q, pend_d;
  logic                     done_q, done_d;
  logic signed [15:0]       prod;
  logic                     start_ok;
  logic                     hs;

  // Shared decodes: accepted start, result handshake, current product
  always_comb begin
    start_ok = (state_q == IDLE) && start && !done_q;
    hs       = (state_q == OUTPUT) && out_ready;
    prod     = act_data * wgt_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = FETCH;
      FETCH:   if (i_q == I_LAST) state_d = DRAIN;
      DRAIN:   state_d = OUTPUT;
      OUTPUT:  if (hs) state_d = (n_q == N_LAST) ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and datapath registers
  always_comb begin
    busy            = (state_q != IDLE);
    done            = done_q;
    out_valid       = (state_q == OUTPUT);
    act_read_enable = (state_q == FETCH);
    wgt_read_enable = (state_q == FETCH);
    act_addr        = i_q;
    wgt_addr        = (WW'(n_q) << AW) | WW'(i_q);
    out_index       = n_q;
`ifdef DENSE_FC_RELU_EN
    out_data        = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    out_data        = acc_q;
`endif
  end

  // Datapath next values: counters, accumulator, product-pending flag, done pulse
  always_comb begin
    i_d    = i_q;
    n_d    = n_q;
    acc_d  = acc_q;
    pend_d = (state_q == FETCH);
    done_d = 1'b0;
    // read data returns one cycle after its strobe, so accumulate on the delayed flag
    if (pend_q) acc_d = acc_q + ACC_W'(prod);
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          acc_d = '0;
          i_d   = '0;
          n_d   = '0;
        end
      end
      FETCH: begin
        i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
      end
      OUTPUT: begin
        if (hs) begin
          if (n_q == N_LAST) begin
            done_d = 1'b1;
          end else begin
            n_d   = n_q + 1'b1;
            acc_d = '0;
            i_d   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      i_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      i_q    <= i_d;
      n_q    <= n_d;
      acc_q  <= acc_d;
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_dense_fc_mac_seq.sv
// Directed bench for dense_fc_mac_seq (IN_LEN=64, OUT_LEN=2, ACC_W=32) with
// synchronous-read activation and weight RAM models.
module tb_dense_fc_mac_seq;

  localparam int IN_LEN  = 64;
  localparam int OUT_LEN = 2;
  localparam int ACC_W   = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [5:0]              act_addr;
  logic                    act_re;
  logic signed [7:0]       act_data = '0;
  logic [6:0]              wgt_addr;
  logic                    wgt_re;
  logic signed [7:0]       wgt_data = '0;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [0:0]              out_index;

  dense_fc_mac_seq #(
    .IN_LEN (IN_LEN),
    .OUT_LEN(OUT_LEN),
    .ACC_W  (ACC_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .act_addr       (act_addr),
    .act_read_enable(act_re),
    .act_data       (act_data),
    .wgt_addr       (wgt_addr),
    .wgt_read_enable(wgt_re),
    .wgt_data       (wgt_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_index      (out_index)
  );

  always #5 clk = ~clk;

  logic signed [7:0] act_mem [IN_LEN];
  logic signed [7:0] wgt_mem [IN_LEN*OUT_LEN];

  // Synchronous-read RAMs: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (act_re) act_data <= act_mem[act_addr];
    if (wgt_re) wgt_data <= wgt_mem[wgt_addr];
  end

  int res_data[$];
  int res_idx[$];
  int done_cnt   = 0;
  int strobe_cnt = 0;
  int max_waddr  = 0;
  int strobe_bad = 0;

  // Monitor: handshakes, done pulses, strobe statistics
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      res_data.push_back(int'(out_data));
      res_idx.push_back(int'(out_index));
    end
    if (done) done_cnt++;
    if (act_re) begin
      strobe_cnt++;
      if (int'(wgt_addr) > max_waddr) max_waddr = int'(wgt_addr);
    end
    if (act_re != wgt_re) strobe_bad++;
  end

  int total = 0;
  int bad   = 0;
  int base_res, base_done, base_strobe;

  typedef struct {
    int mode;
    int a;
    int w0;
    int w1;
    int e0;
    int e1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int expv(input int x);
`ifdef DENSE_FC_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  // mode 0: constants; mode 1: short example zero-padded; mode 2: act ramp 0..63
  task automatic load(input int mode, input int a, input int w0, input int w1);
    for (int i = 0; i < IN_LEN; i++) begin
      case (mode)
        1: begin
          act_mem[i]        = (i < 4) ? 8'(i + 1) : 8'(0);
          wgt_mem[i]        = (i < 4) ? 8'(1) : 8'(0);
          wgt_mem[IN_LEN+i] = (i == 0) ? 8'(-1) : ((i == 3) ? 8'(2) : 8'(0));
        end
        2: begin
          act_mem[i]        = 8'(i);
          wgt_mem[i]        = 8'(w0);
          wgt_mem[IN_LEN+i] = 8'(w1);
        end
        default: begin
          act_mem[i]        = 8'(a);
          wgt_mem[i]        = 8'(w0);
          wgt_mem[IN_LEN+i] = 8'(w1);
        end
      endcase
    end
  endtask

  task automatic snapshot();
    base_res    = res_data.size();
    base_done   = done_cnt;
    base_strobe = strobe_cnt;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done_cnt == base_done && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, " finished"}, int'(k < 1000), 1);
  endtask

  task automatic check_pass(input string name, input int e0, input int e1);
    check({name, " results"}, res_data.size() - base_res, 2);
    if (res_data.size() >= base_res + 2) begin
      check({name, " idx0"},  res_idx[base_res],      0);
      check({name, " data0"}, res_data[base_res],     expv(e0));
      check({name, " idx1"},  res_idx[base_res+1],    1);
      check({name, " data1"}, res_data[base_res+1],   expv(e1));
    end
    check({name, " dones"},   done_cnt - base_done,     1);
    check({name, " strobes"}, strobe_cnt - base_strobe, IN_LEN*OUT_LEN);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"},      int'(busy),      0);
    check({name, " done"},      int'(done),      0);
    check({name, " out_valid"}, int'(out_valid), 0);
    check({name, " act_re"},    int'(act_re),    0);
    check({name, " wgt_re"},    int'(wgt_re),    0);
    check({name, " act_addr"},  int'(act_addr),  0);
    check({name, " wgt_addr"},  int'(wgt_addr),  0);
    check({name, " out_data"},  int'(out_data),  0);
    check({name, " out_index"}, int'(out_index), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int sb;

    vecs[0] = '{1,    0,    0,    0,       10,       7};
    vecs[1] = '{0, -128, -128, -128,  1048576, 1048576};
    vecs[2] = '{0,  127, -128,  127, -1040384, 1032256};
    vecs[3] = '{0,   -1,    1,    0,      -64,       0};
    vecs[4] = '{2,    0,    1,   -2,     2016,   -4032};

    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Table: full passes with the consumer always ready
    for (int v = 0; v < 5; v++) begin
      load(vecs[v].mode, vecs[v].a, vecs[v].w0, vecs[v].w1);
      out_ready = 1'b1;
      snapshot();
      pulse_start();
      wait_done($sformatf("v%0d", v));
      repeat (2) @(posedge clk);
      #1;
      check_pass($sformatf("v%0d", v), vecs[v].e0, vecs[v].e1);
    end

    // Back-pressure: latency to first result, 20-cycle hold, 1-cycle restart
    load(0, 127, -128, 127);
    out_ready = 1'b0;
    snapshot();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 200);
    check("first result latency", k, IN_LEN + 2);
    sb = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || int'(out_data) != expv(-1040384) || out_index != 1'b0 || act_re || wgt_re)
        sb++;
    end
    check("hold stable cycles bad", sb, 0);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("release out_valid", int'(out_valid), 0);
    check("release act_re",    int'(act_re),    1);
    check("release act_addr",  int'(act_addr),  0);
    check("release wgt_addr",  int'(wgt_addr),  IN_LEN);
    check("release out_index", int'(out_index), 1);
    wait_done("hold");
    repeat (2) @(posedge clk);
    #1;
    check_pass("hold", -1040384, 1032256);

    // Reset during FETCH of neuron 1, then a clean restart
    load(2, 0, 1, -2);
    out_ready = 1'b1;
    snapshot();
    pulse_start();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(act_re && out_index == 1'b1) && k < 500);
    check("reach neuron1 fetch", int'(k < 500), 1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    snapshot();
    repeat (10) @(negedge clk);
    check("after reset strobes", strobe_cnt - base_strobe, 0);
    check("after reset results", res_data.size() - base_res, 0);
    pulse_start();
    wait_done("restart");
    repeat (2) @(posedge clk);
    #1;
    check_pass("restart", 2016, -4032);

    // start held high for the whole pass including the done cycle
    load(1, 0, 0, 0);
    out_ready = 1'b1;
    snapshot();
    @(posedge clk);
    #1 start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 1000);
    check("held start done seen", int'(k < 1000), 1);
    check("done cycle busy", int'(busy), 0);
    @(negedge clk);
    check("start in done cycle ignored", int'(busy), 0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle after pass", int'(busy), 0);
    check_pass("held", 10, 7);
    check("max wgt_addr", max_waddr, IN_LEN*OUT_LEN - 1);
    check("strobe pair mismatch cycles", strobe_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
